// File: rtl/fft_in_framer.sv
// Input framer for a block-floating-point FFT: collects samples into a two-bank
// ping-pong buffer and replays each 16/32-sample segment as a gap-free burst.
module fft_in_framer #(
  parameter int MAN_WIDTH = 16,
  parameter int EXP_WIDTH = 6
) (
  input  logic                 clk_sys,
  input  logic                 rst_sys_n,
  input  logic                 start_i,
  input  logic [3:0]           ldn_rg_i,
  input  logic                 smp_val_i,
  output logic                 smp_rdy_o,
  input  logic [MAN_WIDTH-1:0] smp_real_i,
  input  logic [MAN_WIDTH-1:0] smp_imag_i,
  input  logic [EXP_WIDTH-1:0] smp_exp_i,
  output logic                 block_sync_o,
  output logic                 stage_sync_o,
  output logic                 data_val_o,
  output logic [MAN_WIDTH-1:0] data_real_o,
  output logic [MAN_WIDTH-1:0] data_imag_o,
  output logic [EXP_WIDTH-1:0] data_exp_o,
  output logic [3:0]           ldn_rg_o,
  output logic                 busy_o,
  output logic                 cfg_err_o
);

  typedef struct packed {
    logic [MAN_WIDTH-1:0] re;
    logic [MAN_WIDTH-1:0] im;
    logic [EXP_WIDTH-1:0] ex;
  } smp_t;

  typedef enum logic {R_IDLE, R_EMIT} rd_st_e;

  rd_st_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic [3:0]  ldn_q, ldn_d;
  logic        cfg_err_q, cfg_err_d;
  logic [11:0] acc_cnt_q, acc_cnt_d;
  logic [11:0] em_cnt_q, em_cnt_d;
  logic [4:0]  wr_idx_q, wr_idx_d;
  logic        wr_bank_q, wr_bank_d;
  logic [5:0]  rd_idx_q, rd_idx_d;
  logic        rd_bank_q, rd_bank_d;
  logic [1:0]  full_q, full_d;
  logic        first_q, first_d;
  smp_t        out_q, out_d;
  logic        bsync_q, bsync_d;
  logic        ssync_q, ssync_d;

  smp_t        mem_q [2][32];

  logic [11:0] blk_len;
  logic [5:0]  seg_len;
  logic        ldn_ok, start_ok, acc, fill_done, last_cyc, launch, step;
  logic [1:0]  avail;
  smp_t        smp_in;

  assign blk_len  = 12'd1 << ldn_q;
  assign seg_len  = ldn_q[0] ? 6'd32 : 6'd16;
  assign ldn_ok   = (ldn_rg_i >= 4'd4) && (ldn_rg_i <= 4'd11);
  assign start_ok = start_i && !busy_q && ldn_ok;

  assign smp_rdy_o = busy_q && !full_q[wr_bank_q] && (acc_cnt_q < blk_len);
  assign acc       = smp_val_i && smp_rdy_o;
  assign fill_done = acc && ({1'b0, wr_idx_q} == seg_len - 6'd1);
  assign smp_in    = '{re: smp_real_i, im: smp_imag_i, ex: smp_exp_i};

  // A bank completing on this edge counts as full so its burst starts without
  // waiting a cycle for the flag.
  assign avail[0] = full_q[0] || (fill_done && !wr_bank_q);
  assign avail[1] = full_q[1] || (fill_done &&  wr_bank_q);

  assign last_cyc = (state_q == R_EMIT) && (rd_idx_q == seg_len);
  assign launch   = ((state_q == R_IDLE) || last_cyc) && avail[rd_bank_q];
  assign step     = (state_q == R_EMIT) && !last_cyc;

  always_ff @(posedge clk_sys) begin
    if (acc) mem_q[wr_bank_q][wr_idx_q] <= smp_in;
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q   <= R_IDLE;
      busy_q    <= 1'b0;
      ldn_q     <= '0;
      cfg_err_q <= 1'b0;
      acc_cnt_q <= '0;
      em_cnt_q  <= '0;
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      first_q   <= 1'b0;
      out_q     <= '0;
      bsync_q   <= 1'b0;
      ssync_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      ldn_q     <= ldn_d;
      cfg_err_q <= cfg_err_d;
      acc_cnt_q <= acc_cnt_d;
      em_cnt_q  <= em_cnt_d;
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_idx_q  <= rd_idx_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      first_q   <= first_d;
      out_q     <= out_d;
      bsync_q   <= bsync_d;
      ssync_q   <= ssync_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    ldn_d     = ldn_q;
    cfg_err_d = start_i && !start_ok;
    acc_cnt_d = acc_cnt_q;
    em_cnt_d  = em_cnt_q;
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    first_d   = first_q;
    out_d     = '0;
    bsync_d   = 1'b0;
    ssync_d   = 1'b0;

    if (start_ok) begin
      busy_d    = 1'b1;
      ldn_d     = ldn_rg_i;
      acc_cnt_d = '0;
      em_cnt_d  = '0;
      wr_idx_d  = '0;
      wr_bank_d = 1'b0;
      rd_idx_d  = '0;
      rd_bank_d = 1'b0;
      full_d    = '0;
      first_d   = 1'b1;
    end

    if (acc) begin
      acc_cnt_d = acc_cnt_q + 12'd1;
      if (fill_done) begin
        wr_idx_d          = '0;
        wr_bank_d         = !wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 5'd1;
      end
    end

    if (launch) begin
      state_d  = R_EMIT;
      out_d    = mem_q[rd_bank_q][5'd0];
      ssync_d  = 1'b1;
      bsync_d  = first_q;
      first_d  = 1'b0;
      rd_idx_d = 6'd1;
      em_cnt_d = em_cnt_q + 12'd1;
    end else if (step) begin
      out_d    = mem_q[rd_bank_q][rd_idx_q[4:0]];
      rd_idx_d = rd_idx_q + 6'd1;
      em_cnt_d = em_cnt_q + 12'd1;
      // Last entry leaves the bank here; the writer may refill it next cycle.
      if (rd_idx_q == seg_len - 6'd1) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end else if (last_cyc) begin
      state_d  = R_IDLE;
      rd_idx_d = '0;
      if (em_cnt_q == blk_len) busy_d = 1'b0;
    end
  end

  assign data_val_o   = (state_q == R_EMIT);
  assign data_real_o  = out_q.re;
  assign data_imag_o  = out_q.im;
  assign data_exp_o   = out_q.ex;
  assign block_sync_o = bsync_q;
  assign stage_sync_o = ssync_q;
  assign ldn_rg_o     = ldn_q;
  assign busy_o       = busy_q;
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_fft_in_framer.sv
// Randomized bench for fft_in_framer: a cycle-level stream model predicts every
// output burst, handshake ready and control output from the framing rules.
module tb_fft_in_framer;
  localparam int MW = 16;
  localparam int EW = 6;

  logic          clk_sys = 1'b0;
  logic          rst_sys_n = 1'b0;
  logic          start_i = 1'b0;
  logic [3:0]    ldn_rg_i = '0;
  logic          smp_val_i = 1'b0;
  logic [MW-1:0] smp_real_i = '0;
  logic [MW-1:0] smp_imag_i = '0;
  logic [EW-1:0] smp_exp_i = '0;
  logic          smp_rdy_o, block_sync_o, stage_sync_o, data_val_o;
  logic [MW-1:0] data_real_o, data_imag_o;
  logic [EW-1:0] data_exp_o;
  logic [3:0]    ldn_rg_o;
  logic          busy_o, cfg_err_o;

  fft_in_framer #(.MAN_WIDTH(MW), .EXP_WIDTH(EW)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start_i(start_i), .ldn_rg_i(ldn_rg_i),
    .smp_val_i(smp_val_i), .smp_rdy_o(smp_rdy_o), .smp_real_i(smp_real_i),
    .smp_imag_i(smp_imag_i), .smp_exp_i(smp_exp_i), .block_sync_o(block_sync_o),
    .stage_sync_o(stage_sync_o), .data_val_o(data_val_o), .data_real_o(data_real_o),
    .data_imag_o(data_imag_o), .data_exp_o(data_exp_o), .ldn_rg_o(ldn_rg_o),
    .busy_o(busy_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            cyc;
    logic [MW-1:0] re, im;
    logic [EW-1:0] ex;
    bit            ss, bs, lseg, lblk;
  } ent_t;

  ent_t                 sched[$];
  logic [2*MW+EW-1:0]   segbuf[$];
  int   cyc = 0, next_free = 0, held = 0, acc_tot = 0, blk_len = 1, seg = 16;
  int   n_ss = 0, n_bs = 0, n_val = 0;
  bit   m_busy = 0, m_err = 0, first_seg = 0;
  logic [3:0] m_ldn = '0;

  always @(negedge clk_sys) begin
    ent_t        e;
    bit          nb;
    int          s;
    logic [63:0] ev;
    cyc++;
    if (!rst_sys_n) begin
      chk("rst_out", {data_val_o, block_sync_o, stage_sync_o, data_real_o, data_imag_o,
                      data_exp_o, busy_o, cfg_err_o, smp_rdy_o, ldn_rg_o}, 64'd0);
      sched.delete(); segbuf.delete();
      m_busy = 0; m_err = 0; m_ldn = '0; held = 0; acc_tot = 0; blk_len = 1; next_free = 0;
    end else begin
      nb = m_busy;
      ev = '0;
      if (sched.size() > 0 && sched[0].cyc == cyc) begin
        e  = sched.pop_front();
        ev = {23'd0, 1'b1, e.bs, e.ss, e.re, e.im, e.ex};
        if (e.lseg) held--;
        if (e.lblk) nb = 0;
      end
      chk("out", {23'd0, data_val_o, block_sync_o, stage_sync_o, data_real_o, data_imag_o,
                  data_exp_o}, ev);
      chk("ctl", {busy_o, cfg_err_o, ldn_rg_o}, {m_busy, m_err, m_ldn});
      chk("rdy", smp_rdy_o, m_busy && acc_tot < blk_len && held < 2);
      n_val += data_val_o; n_ss += stage_sync_o; n_bs += block_sync_o;

      if (smp_val_i && smp_rdy_o) begin
        segbuf.push_back({smp_real_i, smp_imag_i, smp_exp_i});
        acc_tot++;
        if (segbuf.size() == seg) begin
          s = (cyc + 1 > next_free) ? cyc + 1 : next_free;
          for (int i = 0; i < seg; i++) begin
            e.cyc = s + i;
            {e.re, e.im, e.ex} = segbuf[i];
            e.ss   = (i == 0);
            e.bs   = (i == 0) && first_seg;
            e.lseg = (i == seg - 1);
            e.lblk = (i == seg - 1) && (acc_tot == blk_len);
            sched.push_back(e);
          end
          first_seg = 0; next_free = s + seg; held++; segbuf.delete();
        end
      end

      m_err = start_i && (m_busy || ldn_rg_i < 4 || ldn_rg_i > 11);
      if (start_i && !m_busy && ldn_rg_i >= 4 && ldn_rg_i <= 11) begin
        nb = 1; m_ldn = ldn_rg_i; blk_len = 1 << ldn_rg_i; seg = ldn_rg_i[0] ? 32 : 16;
        acc_tot = 0; first_seg = 1; held = 0; next_free = 0; segbuf.delete();
      end
      m_busy = nb;
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_blk(input logic [3:0] ldn);
    @(posedge clk_sys); #1 start_i = 1'b1; ldn_rg_i = ldn;
    @(posedge clk_sys); #1 start_i = 1'b0;
  endtask

  task automatic send(input int n, input int gap_pct, input bit ramp, input bit cont,
                      input bit spur);
    int sent = 0;
    int t = 0;
    while (sent < n && t < 20000) begin
      @(posedge clk_sys); #1;
      start_i = 1'b0;
      if (spur && $urandom_range(15) == 0) begin
        start_i  = 1'b1;
        ldn_rg_i = 4'($urandom_range(15));
      end
      if ($urandom_range(99) < gap_pct) smp_val_i = 1'b0;
      else begin
        smp_val_i  = 1'b1;
        smp_real_i = MW'(sent + 1);
        smp_imag_i = MW'($urandom);
        smp_exp_i  = ramp ? EW'(sent % 16) : EW'($urandom);
      end
      @(negedge clk_sys);
      if (cont) chk("rdy_cont", smp_rdy_o, 1'b1);
      if (smp_val_i && smp_rdy_o) sent++;
      t++;
    end
    @(posedge clk_sys); #1 smp_val_i = 1'b0; start_i = 1'b0;
    if (t >= 20000) chk("send_timeout", 64'(sent), 64'(n));
  endtask

  task automatic excess(input int k);
    repeat (k) begin
      @(posedge clk_sys); #1 smp_val_i = 1'b1; smp_real_i = 16'hDEAD;
    end
    @(posedge clk_sys); #1 smp_val_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_o && t < 5000) begin @(negedge clk_sys); t++; end
    chk("idle_timeout", busy_o, 1'b0);
    repeat (3) @(negedge clk_sys);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v0, s0, b0;
    repeat (3) @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
    @(negedge clk_sys);
    chk("reset_ldn", ldn_rg_o, 4'd0);

    // ldn=4: 1..16 back-to-back, excess samples ignored
    v0 = n_val; s0 = n_ss; b0 = n_bs;
    start_blk(4'd4);
    send(16, 0, 0, 1, 0);
    excess(4);
    wait_idle();
    chk("t1_val", 64'(n_val - v0), 64'd16);
    chk("t1_ss", 64'(n_ss - s0), 64'd1);
    chk("t1_bs", 64'(n_bs - b0), 64'd1);

    // ldn=5 with random gaps
    v0 = n_val; s0 = n_ss;
    start_blk(4'd5);
    send(32, 30, 0, 0, 0);
    wait_idle();
    chk("t2_val", 64'(n_val - v0), 64'd32);
    chk("t2_ss", 64'(n_ss - s0), 64'd1);
    chk("t2_ldn", ldn_rg_o, 4'd5);

    // ldn=11 continuous
    v0 = n_val; s0 = n_ss; b0 = n_bs;
    start_blk(4'd11);
    send(2048, 0, 0, 1, 0);
    wait_idle();
    chk("t3_val", 64'(n_val - v0), 64'd2048);
    chk("t3_ss", 64'(n_ss - s0), 64'd64);
    chk("t3_bs", 64'(n_bs - b0), 64'd1);

    // illegal size, then start while busy
    @(posedge clk_sys); #1 start_i = 1'b1; ldn_rg_i = 4'd3;
    @(posedge clk_sys); #1 start_i = 1'b0;
    @(negedge clk_sys);
    chk("err_ldn3", {cfg_err_o, busy_o, ldn_rg_o}, {1'b1, 1'b0, 4'd11});
    @(negedge clk_sys);
    chk("err_pulse1", cfg_err_o, 1'b0);
    start_blk(4'd4);
    @(posedge clk_sys); #1 start_i = 1'b1; ldn_rg_i = 4'd7;
    @(posedge clk_sys); #1 start_i = 1'b0;
    @(negedge clk_sys);
    chk("err_busy", {cfg_err_o, busy_o, ldn_rg_o}, {1'b1, 1'b1, 4'd4});
    @(negedge clk_sys);
    chk("err_pulse2", cfg_err_o, 1'b0);
    send(16, 10, 0, 0, 0);
    wait_idle();

    // exponent ramp
    start_blk(4'd4);
    send(16, 0, 1, 1, 0);
    wait_idle();

    // reset mid-block, then a fresh block
    start_blk(4'd8);
    send(40, 0, 0, 1, 0);
    @(posedge clk_sys); #2 rst_sys_n = 1'b0;
    #1 chk("rst_async", {data_val_o, block_sync_o, stage_sync_o, data_real_o, data_imag_o,
                         data_exp_o, busy_o, cfg_err_o, smp_rdy_o, ldn_rg_o}, 64'd0);
    repeat (2) @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
    v0 = n_val;
    repeat (20) @(negedge clk_sys);
    chk("rst_no_val", 64'(n_val - v0), 64'd0);
    v0 = n_val; s0 = n_ss;
    start_blk(4'd6);
    send(64, 20, 0, 0, 0);
    wait_idle();
    chk("t6_val", 64'(n_val - v0), 64'd64);
    chk("t6_ss", 64'(n_ss - s0), 64'd4);

    // random blocks with spurious starts
    for (int k = 0; k < 6; k++) begin
      logic [3:0] l;
      l = 4'($urandom_range(9, 4));
      start_blk(l);
      send(1 << l, $urandom_range(50), 0, 0, 1);
      excess(3);
      wait_idle();
    end

    repeat (5) @(negedge clk_sys);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fft_in_framer.md
FFT_IN_FRAMER -- requirements
Module: fft_in_framer

Interface
REQ-001 Parameter MAN_WIDTH, default 16, signed mantissa width of real/imag samples.
REQ-002 Parameter EXP_WIDTH, default 6, signed block-floating-point exponent width.
REQ-003 clk_sys  input  1  system clock, all state on rising edge.
REQ-004 rst_sys_n  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  one-cycle pulse, opens a new transform block, latches ldn_rg_i.
REQ-006 ldn_rg_i  input  4  log2 of transform size, legal 4..11.
REQ-007 smp_val_i / smp_rdy_o  input / output  1 / 1  sample handshake; transfer when both high.
REQ-008 smp_real_i, smp_imag_i  input  MAN_WIDTH each  signed sample mantissas.
REQ-009 smp_exp_i  input  EXP_WIDTH  signed sample exponent.
REQ-010 block_sync_o, stage_sync_o, data_val_o  output  1 each  stream framing toward pipeline stage I.
REQ-011 data_real_o, data_imag_o / data_exp_o  output  MAN_WIDTH / EXP_WIDTH  framed sample.
REQ-012 ldn_rg_o  output  4  latched transform size for the current block.
REQ-013 busy_o  output  1  block in progress; cfg_err_o  output  1  one-cycle error pulse.

Function
REQ-014 Segment length SEG = 16 when latched ldn is even, 32 when odd; block length 2^ldn; segments per block 2^ldn/SEG.
REQ-015 Start accepted only when busy_o=0 and ldn_rg_i in 4..11: ldn latched, busy_o set next edge, smp_rdy_o may rise next cycle.
REQ-016 start_i with ldn_rg_i outside 4..11, or while busy_o=1: ignored, cfg_err_o high for exactly one cycle.
REQ-017 Two-bank ping-pong buffer, 32 entries per bank, each entry {real, imag, exp}; write side fills one bank with one SEG-sample segment.
REQ-018 Bank marked full on the edge its SEG-th sample is accepted; write side then switches to the other bank.
REQ-019 smp_rdy_o = busy_o AND current write bank empty AND fewer than 2^ldn samples accepted this block.
REQ-020 After 2^ldn samples accepted: smp_rdy_o low until next accepted start; excess smp_val_i ignored.
REQ-021 Read FSM states R_IDLE, R_EMIT; R_IDLE->R_EMIT when a bank is full; R_EMIT lasts exactly SEG consecutive cycles, data_val_o high each cycle, no gaps.
REQ-022 Latency: first sample of a segment on outputs in the cycle after the edge accepting that segment's last sample (outputs registered).
REQ-023 End of R_EMIT with the other bank full: next segment emitted in the immediately following cycle; otherwise R_IDLE.
REQ-024 Bank freed on the edge its last entry is emitted; freed bank may be written from the next cycle.
REQ-025 Emission order: sample 0 first within a segment, segments in acceptance order; data and exponent bit-exact pass-through, no scaling.
REQ-026 stage_sync_o high with the first sample of every segment; block_sync_o high with first sample of first segment of the block only.
REQ-027 ldn_rg_o updated at start acceptance, held until next accepted start.
REQ-028 busy_o clears on the edge after the last sample of the block is emitted.
REQ-029 When data_val_o=0: data_real_o, data_imag_o, data_exp_o, block_sync_o, stage_sync_o all zero.
REQ-030 Continuous 1-sample/cycle input never deasserts smp_rdy_o within a block.

Reset
REQ-031 Reset asynchronously clears all outputs to 0 (ldn_rg_o 0, smp_rdy_o 0, busy_o 0), both banks to empty, FSMs to R_IDLE and write-idle; buffered data is discarded.
REQ-032 Reset mid-block abandons the block; no partial segment emitted after release; next legal start operates normally.
REQ-033 Buffer contents are not reset; only occupancy flags are.

Verification
REQ-034 ldn=4, start, 16 samples back-to-back values 1..16 -> one 16-cycle burst 1..16, block_sync_o and stage_sync_o on first only, first output 1 cycle after 16th accept, busy_o low after.
REQ-035 ldn=5, 32 samples with random smp_val_i gaps -> one contiguous 32-cycle burst, data order preserved, ldn_rg_o=5.
REQ-036 ldn=11, 2048 continuous samples -> 64 bursts of 32, 64 stage_sync_o pulses, 1 block_sync_o, smp_rdy_o never low during block, bursts back-to-back.
REQ-037 start_i with ldn_rg_i=3, then start_i while busy -> cfg_err_o one-cycle pulse each, no busy_o change, latched ldn unchanged.
REQ-038 ldn=8, assert rst_sys_n low after 40 samples -> all outputs 0 immediately, no further data_val_o; new start ldn=6, 64 samples -> 4 correct 16-sample bursts.
REQ-039 Per-sample exponent ramp 0..15 on smp_exp_i, ldn=4 -> data_exp_o reproduces 0..15 aligned with samples.
